// File: rtl/lcd_frame_writer_if.sv
// Frame handshake and LCD pin bundle for lcd_frame_writer.
// The font code macros live here so the writer and anything driving
// it agree on the encoding of the non-digit glyphs.

`ifndef FONT_A
`define FONT_A    6'd20
`endif
`ifndef FONT_M
`define FONT_M    6'd22
`endif
`ifndef FONT_P
`define FONT_P    6'd25
`endif
`ifndef FONT_NONE
`define FONT_NONE 6'd31
`endif

interface lcd_frame_writer_if;
    logic [95:0] data_in;
    logic        frame_valid;
    logic        frame_ready;
    logic        init_done;
    logic        lcd_e;
    logic        lcd_rs;
    logic        lcd_rw;
    logic [7:0]  lcd_data;

    // frame producer / LCD observer side
    modport master (
        output data_in, frame_valid,
        input  frame_ready, init_done, lcd_e, lcd_rs, lcd_rw, lcd_data
    );

    // the writer itself
    modport slave (
        input  data_in, frame_valid,
        output frame_ready, init_done, lcd_e, lcd_rs, lcd_rw, lcd_data
    );
endinterface

// File: rtl/lcd_frame_writer.sv
// Snapshots a 16-char packed frame and writes it to an HD44780-style
// character LCD: power-on wait, 4-byte init, then per frame an address
// command plus 8 chars for each of the two lines. A single byte engine
// produces the setup / E-pulse / hold timing for every byte.

module lcd_frame_writer #(
    parameter int T_POWER = 15000,
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 12,
    parameter int T_HOLD  = 40,
    parameter int T_CLEAR = 1640
) (
    input  logic               clk,
    input  logic               rst_n,
    lcd_frame_writer_if.slave  bus
);

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        LINE1_ADDR,
        LINE1_CHARS,
        LINE2_ADDR,
        LINE2_CHARS
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } phase_t;

    state_t      state, state_nxt;
    phase_t      phase;
    logic [15:0] tmr;
    logic [3:0]  idx, idx_nxt;
    logic [1:0]  init_idx, init_idx_nxt;
    logic [95:0] snap;
    logic        hold_clear;
    logic        init_done_q;
    logic        lcd_e_q, lcd_rs_q;
    logic [7:0]  lcd_data_q;

    logic        byte_last;
    logic        issue, issue_rs, issue_clear;
    logic [7:0]  issue_data;
    logic        capture, set_init_done;
    logic [3:0]  char_sel;
    logic [5:0]  char_code;
    logic [7:0]  char_byte;

    // Font code to LCD character ROM code; anything unknown is a blank.
    function automatic logic [7:0] font_xlate(input logic [5:0] code);
        if (code <= 6'd9)
            return 8'h30 + {2'b00, code};
        else if (code == `FONT_A)
            return 8'h41;
        else if (code == `FONT_M)
            return 8'h4D;
        else if (code == `FONT_P)
            return 8'h50;
        else
            return 8'h20;
    endfunction

    // Function set 8-bit/2-line, display on, entry increment, clear.
    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Last cycle of the current byte's hold; the next byte issues on this edge.
    assign byte_last = (phase == PH_HOLD) && (tmr == 16'd0);

    // While inside a line the byte being issued is the next char down;
    // on the address command it is the char the index already points at.
    assign char_sel  = ((state == LINE1_CHARS) || (state == LINE2_CHARS)) ? idx - 4'd1 : idx;
    assign char_code = snap[{3'd0, char_sel} * 7'd6 +: 6];
    assign char_byte = font_xlate(char_code);

    // Sequencer: decides which byte goes out next and when.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        init_idx_nxt  = init_idx;
        issue         = 1'b0;
        issue_rs      = 1'b0;
        issue_data    = 8'h00;
        issue_clear   = 1'b0;
        capture       = 1'b0;
        set_init_done = 1'b0;
        case (state)
            PWR_WAIT: begin
                if (tmr == 16'(T_POWER - 1)) begin
                    issue        = 1'b1;
                    issue_data   = init_cmd(2'd0);
                    init_idx_nxt = 2'd0;
                    state_nxt    = INIT;
                end
            end
            INIT: begin
                if (byte_last) begin
                    if (init_idx == 2'd3) begin
                        set_init_done = 1'b1;
                        state_nxt     = IDLE;
                    end else begin
                        init_idx_nxt = init_idx + 2'd1;
                        issue        = 1'b1;
                        issue_data   = init_cmd(init_idx + 2'd1);
                        issue_clear  = (init_idx == 2'd2);
                    end
                end
            end
            IDLE: begin
                if (bus.frame_valid) begin
                    capture    = 1'b1;
                    issue      = 1'b1;
                    issue_data = 8'h80;
                    idx_nxt    = 4'd15;
                    state_nxt  = LINE1_ADDR;
                end
            end
            LINE1_ADDR: begin
                if (byte_last) begin
                    issue      = 1'b1;
                    issue_rs   = 1'b1;
                    issue_data = char_byte;
                    state_nxt  = LINE1_CHARS;
                end
            end
            LINE1_CHARS: begin
                if (byte_last) begin
                    issue   = 1'b1;
                    idx_nxt = idx - 4'd1;
                    if (idx == 4'd8) begin
                        issue_data = 8'hC0;
                        state_nxt  = LINE2_ADDR;
                    end else begin
                        issue_rs   = 1'b1;
                        issue_data = char_byte;
                    end
                end
            end
            LINE2_ADDR: begin
                if (byte_last) begin
                    issue      = 1'b1;
                    issue_rs   = 1'b1;
                    issue_data = char_byte;
                    state_nxt  = LINE2_CHARS;
                end
            end
            LINE2_CHARS: begin
                if (byte_last) begin
                    if (idx == 4'd0) begin
                        state_nxt = IDLE;
                    end else begin
                        issue      = 1'b1;
                        issue_rs   = 1'b1;
                        issue_data = char_byte;
                        idx_nxt    = idx - 4'd1;
                    end
                end
            end
            default: state_nxt = PWR_WAIT;
        endcase
    end

    // Sequencer state, char/init indices, sticky init flag and frame snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PWR_WAIT;
            idx         <= 4'd0;
            init_idx    <= 2'd0;
            init_done_q <= 1'b0;
            snap        <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            init_idx <= init_idx_nxt;
            if (set_init_done)
                init_done_q <= 1'b1;
            if (capture)
                snap <= bus.data_in;
        end
    end

    // Byte engine: setup, E pulse, hold; the timer doubles as the
    // power-on counter while nothing is being transferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= PH_IDLE;
            tmr        <= 16'd0;
            hold_clear <= 1'b0;
            lcd_e_q    <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= 8'h00;
        end else if (issue) begin
            phase      <= PH_SETUP;
            tmr        <= 16'(T_SETUP - 1);
            hold_clear <= issue_clear;
            lcd_e_q    <= 1'b0;
            lcd_rs_q   <= issue_rs;
            lcd_data_q <= issue_data;
        end else begin
            case (phase)
                PH_IDLE: begin
                    if (state == PWR_WAIT)
                        tmr <= tmr + 16'd1;
                end
                PH_SETUP: begin
                    if (tmr != 16'd0) begin
                        tmr <= tmr - 16'd1;
                    end else begin
                        phase   <= PH_PULSE;
                        tmr     <= 16'(T_PULSE - 1);
                        lcd_e_q <= 1'b1;
                    end
                end
                PH_PULSE: begin
                    if (tmr != 16'd0) begin
                        tmr <= tmr - 16'd1;
                    end else begin
                        phase   <= PH_HOLD;
                        tmr     <= hold_clear ? 16'(T_CLEAR - 1) : 16'(T_HOLD - 1);
                        lcd_e_q <= 1'b0;
                    end
                end
                default: begin
                    if (tmr != 16'd0)
                        tmr <= tmr - 16'd1;
                    else
                        phase <= PH_IDLE;
                end
            endcase
        end
    end

    assign bus.frame_ready = (state == IDLE);
    assign bus.init_done   = init_done_q;
    assign bus.lcd_e       = lcd_e_q;
    assign bus.lcd_rs      = lcd_rs_q;
    assign bus.lcd_rw      = 1'b0;
    assign bus.lcd_data    = lcd_data_q;

endmodule

// File: doc/lcd_frame_writer.md
Name: lcd_frame_writer

Overview:
- Consumer of the 96-bit packed display frame: 16 six-bit font codes, char 15 in [95:90] down to char 0 in [5:0].
- Snapshots a frame, translates each font code to an 8-bit character code and writes it to an HD44780-style character LCD over an 8-bit parallel bus with E-strobe timing.
- Line 1 shows chars 15..8 (date). Line 2 shows chars 7..0 (AM/PM + time).
- Runs the LCD power-on init sequence once after reset.

Parameters:
- T_POWER, 15000: idle cycles after reset before the first init command.
- T_SETUP, 2: cycles RS/DB are stable before E rises.
- T_PULSE, 12: cycles E is held high.
- T_HOLD, 40: cycles after E falls before the next byte may start; RS/DB stay held.
- T_CLEAR, 1640: T_HOLD replacement used after the clear-display command (0x01).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- data_in  in  96  packed frame, 16 x 6-bit font codes
- frame_valid  in  1  frame offered this cycle
- frame_ready  out  1  block can accept a frame
- init_done  out  1  LCD init sequence complete, sticky until reset
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  tied 0, write only
- lcd_data  out  8  LCD data bus

Behaviour:
- Reset (async, rst_n=0): all outputs 0, including frame_ready and init_done. FSM goes to PWR_WAIT and all counters clear. Asserting reset mid-write aborts the write: lcd_e drops immediately and the full init sequence reruns after release.
- FSM states: PWR_WAIT → INIT (4 bytes) → IDLE → LINE1_ADDR → LINE1_CHARS (8) → LINE2_ADDR → LINE2_CHARS (8) → IDLE.
- PWR_WAIT: count T_POWER cycles, then enter INIT.
- INIT: send commands 0x38, 0x0C, 0x06, 0x01 in that order. Byte 0x01 uses T_CLEAR in place of T_HOLD. After the last byte, set init_done=1 and enter IDLE.
- Byte transfer engine, shared by all states. The issue cycle loads lcd_rs and lcd_data.
  - lcd_e=1 starting T_SETUP cycles after the issue cycle, for exactly T_PULSE cycles.
  - lcd_e=0 afterwards for T_HOLD (or T_CLEAR) cycles.
  - lcd_rs and lcd_data stay stable for the whole transfer.
  - Transfer length is T_SETUP+T_PULSE+T_HOLD cycles. The next byte's issue cycle immediately follows.
- IDLE: frame_ready=1.
  - Accept when frame_valid && frame_ready: capture data_in into a 96-bit snapshot register.
  - frame_ready=0 from the following cycle.
  - frame_valid while frame_ready=0 is ignored, not queued. data_in changes after acceptance do not affect the write in progress.
- Frame write, 18 bytes:
  - cmd 0x80, then data chars 15..8.
  - cmd 0xC0, then data chars 7..0.
- Return to IDLE: frame_ready reasserts the cycle after the T_HOLD of the final char expires.
- Font translation, combinational on the current char of the snapshot:
  - codes 6'd0–6'd9 → 0x30–0x39.
  - `FONT_A`→0x41, `FONT_M`→0x4D, `FONT_P`→0x50.
  - `FONT_NONE` and every other code → 0x20.
- Character index counter: 4 bits, counts 15 down to 0. Wrap-around is never used; the FSM leaves the state at index 8 (line 1) and index 0 (line 2).
- Timing counter: 16 bits, loaded per phase, counts to zero. Every parameter must be ≥1.
- lcd_rw is constant 0.

Test Plan (use T_POWER=10, T_SETUP=2, T_PULSE=3, T_HOLD=4, T_CLEAR=8):
- Reset release → lcd_e stays 0 for 10 cycles. Then bytes 0x38, 0x0C, 0x06, 0x01 appear with rs=0. init_done rises after the 0x01 hold of 8 cycles, and frame_ready=1 in the same cycle as IDLE.
- Frame with year 2015, month 06, day 15, `FONT_P` `FONT_M`, hour 0 3, min 2 5, sec 4 7 → 18 byte writes, in order:
  - 0x80, "20150615"
  - 0xC0, "PM032547"
  - Each E high pulse is exactly 3 cycles; rs=0 only on 0x80 and 0xC0.
- Change data_in the cycle after acceptance → bytes written still match the captured frame. frame_valid pulses during the write produce no extra writes.
- Codes `FONT_NONE`, 6'd63 and 6'd10 → written as 0x20.
- Drop rst_n while lcd_e=1 during char 12 → lcd_e=0, frame_ready=0 and init_done=0 immediately. After release, the full init sequence repeats before any frame is accepted.
- frame_valid held high continuously → back-to-back frames. Exactly 1 IDLE cycle with frame_ready=1 between frames; each frame takes 18×9 cycles plus the accept cycle.
